// File: rtl/decode_stage_if.sv
// IF/ID-to-ID/EX bundle for the decode stage: fetch-side inputs, stall back-pressure,
// the registered ID/EX control/operand bundle and the performance counters.
interface decode_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int REG_NUM_WIDTH = 5,
   parameter int COUNT_WIDTH   = 16
);
   logic                     inValid;
   logic [31:0]              insn;
   logic                     flush;
   logic                     stall;
   logic                     exValid;
   logic [5:0]               exOp;
   logic [REG_NUM_WIDTH-1:0] exRs;
   logic [REG_NUM_WIDTH-1:0] exRt;
   logic [REG_NUM_WIDTH-1:0] exRd;
   logic [REG_NUM_WIDTH-1:0] exWrReg;
   logic [4:0]               exShamt;
   logic [DATA_WIDTH-1:0]    exImm;
   logic [25:0]              exJumpTarget;
   logic [3:0]               exAluCode;
   logic                     exAluSrc;
   logic                     exMemToReg;
   logic                     exRegWrite;
   logic                     exMemRead;
   logic                     exMemWrite;
   logic                     exBranch;
   logic                     exBranchNe;
   logic                     exJump;
   logic                     exIllegal;
   logic [COUNT_WIDTH-1:0]   decodeCount;
   logic [COUNT_WIDTH-1:0]   stallCount;

   modport master (
      output inValid, insn, flush,
      input  stall, exValid, exOp, exRs, exRt, exRd, exWrReg, exShamt, exImm,
             exJumpTarget, exAluCode, exAluSrc, exMemToReg, exRegWrite, exMemRead,
             exMemWrite, exBranch, exBranchNe, exJump, exIllegal, decodeCount, stallCount
   );

   modport slave (
      input  inValid, insn, flush,
      output stall, exValid, exOp, exRs, exRt, exRd, exWrReg, exShamt, exImm,
             exJumpTarget, exAluCode, exAluSrc, exMemToReg, exRegWrite, exMemRead,
             exMemWrite, exBranch, exBranchNe, exJump, exIllegal, decodeCount, stallCount
   );
endinterface

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: control decode, load-use stall against the instruction
// last issued, ID/EX register with flush, and saturating decode/stall counters.
module decode_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int REG_NUM_WIDTH = 5,
   parameter int COUNT_WIDTH   = 16,
   parameter int HAZARD_EN     = 1
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus_if
);
   localparam int OP_POS    = 26;
   localparam int RS_POS    = 21;
   localparam int RT_POS    = 16;
   localparam int RD_POS    = 11;
   localparam int SHAMT_POS = 6;
   localparam int FUNCT_POS = 0;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ADD is code 0 so a bubble (all-zero bundle) reads as a harmless ADD
   localparam logic [3:0] ALU_CODE_ADD = 4'd0;
   localparam logic [3:0] ALU_CODE_SUB = 4'd1;
   localparam logic [3:0] ALU_CODE_AND = 4'd2;
   localparam logic [3:0] ALU_CODE_OR  = 4'd3;
   localparam logic [3:0] ALU_CODE_SLT = 4'd4;

   typedef struct packed {
      logic                     valid;
      logic [5:0]               op;
      logic [REG_NUM_WIDTH-1:0] rs;
      logic [REG_NUM_WIDTH-1:0] rt;
      logic [REG_NUM_WIDTH-1:0] rd;
      logic [REG_NUM_WIDTH-1:0] wr_reg;
      logic [4:0]               shamt;
      logic [DATA_WIDTH-1:0]    imm;
      logic [25:0]              jump_target;
      logic [3:0]               alu_code;
      logic                     alu_src;
      logic                     mem_to_reg;
      logic                     reg_write;
      logic                     mem_read;
      logic                     mem_write;
      logic                     branch;
      logic                     branch_ne;
      logic                     jump;
      logic                     illegal;
   } ex_t;

   ex_t ex_q, ex_d, dec;

   logic [5:0]               op, funct;
   logic [REG_NUM_WIDTH-1:0] rs, rt, rd;
   logic                     reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
   logic                     branch, branch_ne, jump, illegal;
   logic [3:0]               alu_code;
   logic                     rs_used, rt_used, hazard, v;
   logic [COUNT_WIDTH-1:0]   decode_cnt_q, decode_cnt_d, stall_cnt_q, stall_cnt_d;

   assign op    = bus_if.insn[OP_POS +: 6];
   assign funct = bus_if.insn[FUNCT_POS +: 6];
   assign rs    = bus_if.insn[RS_POS +: REG_NUM_WIDTH];
   assign rt    = bus_if.insn[RT_POS +: REG_NUM_WIDTH];
   assign rd    = bus_if.insn[RD_POS +: REG_NUM_WIDTH];
   assign v     = bus_if.inValid;

   always_comb begin
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      jump       = 1'b0;
      illegal    = 1'b0;
      alu_code   = ALU_CODE_ADD;
      case (op)
         OP_R: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            case (funct)
               FN_ADD:  alu_code = ALU_CODE_ADD;
               FN_SUB:  alu_code = ALU_CODE_SUB;
               FN_AND:  alu_code = ALU_CODE_AND;
               FN_OR:   alu_code = ALU_CODE_OR;
               FN_SLT:  alu_code = ALU_CODE_SLT;
               default: begin
                  reg_dst   = 1'b0;
                  reg_write = 1'b0;
                  illegal   = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            mem_read   = 1'b1;
         end
         OP_SW: begin
            alu_src   = 1'b1;
            mem_write = 1'b1;
         end
         OP_BEQ: begin
            branch   = 1'b1;
            alu_code = ALU_CODE_SUB;
         end
         OP_BNE: begin
            branch    = 1'b1;
            branch_ne = 1'b1;
            alu_code  = ALU_CODE_SUB;
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            alu_src   = 1'b1;
            reg_write = 1'b1;
            if (op == OP_SLTI)      alu_code = ALU_CODE_SLT;
            else if (op == OP_ANDI) alu_code = ALU_CODE_AND;
            else if (op == OP_ORI)  alu_code = ALU_CODE_OR;
         end
         OP_J:    jump    = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      dec             = '0;
      dec.valid       = v;
      dec.op          = op;
      dec.rs          = rs;
      dec.rt          = rt;
      dec.rd          = rd;
      dec.wr_reg      = (reg_dst && v) ? rd : rt;
      dec.shamt       = bus_if.insn[SHAMT_POS +: 5];
      dec.imm         = (op == OP_ANDI || op == OP_ORI) ?
                        {{(DATA_WIDTH-16){1'b0}}, bus_if.insn[15:0]} :
                        {{(DATA_WIDTH-16){bus_if.insn[15]}}, bus_if.insn[15:0]};
      dec.jump_target = bus_if.insn[25:0];
      dec.alu_code    = alu_code;
      dec.alu_src     = alu_src & v;
      dec.mem_to_reg  = mem_to_reg & v;
      dec.reg_write   = reg_write & v;
      dec.mem_read    = mem_read & v;
      dec.mem_write   = mem_write & v;
      dec.branch      = branch & v;
      dec.branch_ne   = branch_ne & v;
      dec.jump        = jump & v;
      dec.illegal     = illegal & v;
   end

   // rt of an I-type ALU op or load is a destination, not a source
   assign rs_used = (op != OP_J);
   assign rt_used = (op == OP_R) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);

   assign hazard = (HAZARD_EN != 0) && v && ex_q.valid && ex_q.mem_read &&
                   (ex_q.wr_reg != '0) &&
                   ((rs_used && (ex_q.wr_reg == rs)) || (rt_used && (ex_q.wr_reg == rt)));

   assign bus_if.stall = hazard && !bus_if.flush;

   always_comb begin
      ex_d         = (bus_if.flush || hazard) ? '0 : dec;
      decode_cnt_d = decode_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      if (ex_d.valid && (decode_cnt_q != '1)) decode_cnt_d = decode_cnt_q + COUNT_WIDTH'(1);
      if (bus_if.stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + COUNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q         <= '0;
         decode_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         ex_q         <= ex_d;
         decode_cnt_q <= decode_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign bus_if.exValid      = ex_q.valid;
   assign bus_if.exOp         = ex_q.op;
   assign bus_if.exRs         = ex_q.rs;
   assign bus_if.exRt         = ex_q.rt;
   assign bus_if.exRd         = ex_q.rd;
   assign bus_if.exWrReg      = ex_q.wr_reg;
   assign bus_if.exShamt      = ex_q.shamt;
   assign bus_if.exImm        = ex_q.imm;
   assign bus_if.exJumpTarget = ex_q.jump_target;
   assign bus_if.exAluCode    = ex_q.alu_code;
   assign bus_if.exAluSrc     = ex_q.alu_src;
   assign bus_if.exMemToReg   = ex_q.mem_to_reg;
   assign bus_if.exRegWrite   = ex_q.reg_write;
   assign bus_if.exMemRead    = ex_q.mem_read;
   assign bus_if.exMemWrite   = ex_q.mem_write;
   assign bus_if.exBranch     = ex_q.branch;
   assign bus_if.exBranchNe   = ex_q.branch_ne;
   assign bus_if.exJump       = ex_q.jump;
   assign bus_if.exIllegal    = ex_q.illegal;
   assign bus_if.decodeCount  = decode_cnt_q;
   assign bus_if.stallCount   = stall_cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized instruction streams
// checked against a table-driven decode/hazard model.
module tb_decode_stage;
   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_SLT = 4'd4;

   localparam logic [31:0] I_LW2    = 32'h8C220004;  // lw  $2,4($1)
   localparam logic [31:0] I_ADD3   = 32'h00441820;  // add $3,$2,$4
   localparam logic [31:0] I_LW0    = 32'h8C200004;  // lw  $0,4($1)
   localparam logic [31:0] I_ADD3_0 = 32'h00041820;  // add $3,$0,$4
   localparam logic [31:0] I_LW3    = 32'h8C430000;  // lw  $3,0($2)
   localparam logic [31:0] I_ADD4   = 32'h00632020;  // add $4,$3,$3

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, wr, shamt;
      logic [31:0] imm;
      logic [25:0] jt;
      logic [3:0]  alu;
      logic        alusrc, memtoreg, regwrite, memread, memwrite, branch, branchne, jump, illegal;
   } ex_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   decode_stage_if                  bus ();
   decode_stage_if                  bus_nh ();
   decode_stage_if #(.COUNT_WIDTH(4)) bus_sat ();

   decode_stage                                      dut     (.clk(clk), .rst(rst), .bus_if(bus));
   decode_stage #(.HAZARD_EN(0))                     dut_nh  (.clk(clk), .rst(rst), .bus_if(bus_nh));
   decode_stage #(.COUNT_WIDTH(4))                   dut_sat (.clk(clk), .rst(rst), .bus_if(bus_sat));

   int   n_cmp = 0;
   int   n_bad = 0;
   ex_t  m_ex;
   int   m_dec, m_stall;
   logic exp_stall, obs_stall, obs_stall_nh;

   function automatic int sat(input int x, input int mx);
      return (x > mx) ? mx : x;
   endfunction

   function automatic ex_t dut_ex();
      ex_t e;
      e.valid = bus.exValid;       e.op = bus.exOp;
      e.rs = bus.exRs;             e.rt = bus.exRt;        e.rd = bus.exRd;
      e.wr = bus.exWrReg;          e.shamt = bus.exShamt;  e.imm = bus.exImm;
      e.jt = bus.exJumpTarget;     e.alu = bus.exAluCode;
      e.alusrc = bus.exAluSrc;     e.memtoreg = bus.exMemToReg;
      e.regwrite = bus.exRegWrite; e.memread = bus.exMemRead;
      e.memwrite = bus.exMemWrite; e.branch = bus.exBranch;
      e.branchne = bus.exBranchNe; e.jump = bus.exJump;
      e.illegal = bus.exIllegal;
      return e;
   endfunction

   // Control vector order: regDst,aluSrc,memToReg,regWrite,memRead,memWrite,branch,branchNe,jump
   function automatic ex_t ref_decode(input logic v, input logic [31:0] w);
      ex_t        e;
      logic [8:0] c;
      logic [3:0] a;
      logic       ill;
      logic [5:0] op;
      op = w[31:26]; a = A_ADD; ill = 1'b0; c = 9'b0;
      case (op)
         6'h00: begin
            c = 9'b100100000;
            case (w[5:0])
               6'h20: a = A_ADD;
               6'h22: a = A_SUB;
               6'h24: a = A_AND;
               6'h25: a = A_OR;
               6'h2A: a = A_SLT;
               default: begin c = 9'b0; ill = 1'b1; end
            endcase
         end
         6'h23: c = 9'b011110000;
         6'h2B: c = 9'b010001000;
         6'h04: begin c = 9'b000000100; a = A_SUB; end
         6'h05: begin c = 9'b000000110; a = A_SUB; end
         6'h08: c = 9'b010100000;
         6'h0A: begin c = 9'b010100000; a = A_SLT; end
         6'h0C: begin c = 9'b010100000; a = A_AND; end
         6'h0D: begin c = 9'b010100000; a = A_OR;  end
         6'h02: c = 9'b000000001;
         default: ill = 1'b1;
      endcase
      if (!v) begin c = 9'b0; ill = 1'b0; end
      e.valid = v; e.op = op;
      e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11]; e.shamt = w[10:6];
      e.wr = c[8] ? w[15:11] : w[20:16];
      e.imm = (op == 6'h0C || op == 6'h0D) ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      e.jt = w[25:0]; e.alu = a;
      {e.alusrc, e.memtoreg, e.regwrite, e.memread, e.memwrite, e.branch, e.branchne, e.jump} = c[7:0];
      e.illegal = ill;
      return e;
   endfunction

   function automatic logic ref_hazard(input logic v, input logic [31:0] w);
      logic [5:0] op;
      logic       rs_src, rt_src;
      op     = w[31:26];
      rs_src = (op != 6'h02) && (m_ex.wr == w[25:21]);
      rt_src = (op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2B) && (m_ex.wr == w[20:16]);
      return v && m_ex.valid && m_ex.memread && (m_ex.wr != 5'd0) && (rs_src || rt_src);
   endfunction

   function automatic logic [31:0] rand_insn();
      logic [5:0] ops [11];
      logic [5:0] fns [6];
      logic [31:0] w;
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 10)];
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 5)];
      return w;
   endfunction

   // Drive one cycle on all instances, sample stall mid-cycle, advance the model.
   task automatic tick(input logic v, input logic [31:0] w, input logic f, input logic r);
      logic hz;
      rst = r;
      bus.inValid = v;     bus.insn = w;     bus.flush = f;
      bus_nh.inValid = v;  bus_nh.insn = w;  bus_nh.flush = f;
      bus_sat.inValid = v; bus_sat.insn = w; bus_sat.flush = f;
      #4;
      obs_stall    = bus.stall;
      obs_stall_nh = bus_nh.stall;
      hz           = ref_hazard(v, w);
      exp_stall    = hz && !f;
      if (r) begin
         m_ex = '0; m_dec = 0; m_stall = 0;
      end else begin
         m_ex = (f || hz) ? ex_t'('0) : ref_decode(v, w);
         if (m_ex.valid) m_dec++;
         if (exp_stall) m_stall++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      n_cmp++;
      if (dut_ex() !== ex_t'('0)) begin
         n_bad++; $display("FAIL reset_bundle: got %h want 0", dut_ex());
      end
      n_cmp++;
      if (bus.decodeCount !== 16'd0 || bus.stallCount !== 16'd0) begin
         n_bad++; $display("FAIL reset_counts: got dec=%0d stall=%0d want 0/0", bus.decodeCount, bus.stallCount);
      end
   endtask

   task automatic test_lw();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, I_LW2, 1'b0, 1'b0);
      n_cmp++;
      if (bus.exMemRead !== 1'b1 || bus.exWrReg !== 5'd2 || bus.exImm !== 32'h4 || bus.decodeCount !== 16'd1) begin
         n_bad++;
         $display("FAIL lw_issue: got memread=%b wr=%0d imm=%h dec=%0d want 1/2/00000004/1",
                  bus.exMemRead, bus.exWrReg, bus.exImm, bus.decodeCount);
      end
      n_cmp++;
      if (dut_ex() !== m_ex) begin
         n_bad++; $display("FAIL lw_bundle: got %h want %h", dut_ex(), m_ex);
      end
   endtask

   task automatic test_load_use();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, I_LW2, 1'b0, 1'b0);
      tick(1'b1, I_ADD3, 1'b0, 1'b0);
      n_cmp++;
      if (obs_stall !== 1'b1 || bus.exValid !== 1'b0) begin
         n_bad++; $display("FAIL lu_stall: got stall=%b exValid=%b want 1/0", obs_stall, bus.exValid);
      end
      n_cmp++;
      if (obs_stall_nh !== 1'b0) begin
         n_bad++; $display("FAIL lu_hazard_disabled: got stall=%b want 0", obs_stall_nh);
      end
      tick(1'b1, I_ADD3, 1'b0, 1'b0);
      n_cmp++;
      if (obs_stall !== 1'b0 || bus.exValid !== 1'b1 || bus.exAluCode !== A_ADD ||
          bus.exWrReg !== 5'd3 || bus.stallCount !== 16'd1) begin
         n_bad++;
         $display("FAIL lu_release: got stall=%b v=%b alu=%0d wr=%0d sc=%0d want 0/1/0/3/1",
                  obs_stall, bus.exValid, bus.exAluCode, bus.exWrReg, bus.stallCount);
      end
   endtask

   task automatic test_zero_reg();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, I_LW0, 1'b0, 1'b0);
      tick(1'b1, I_ADD3_0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_stall !== 1'b0 || bus.exValid !== 1'b1 || bus.exWrReg !== 5'd3) begin
         n_bad++; $display("FAIL zero_reg: got stall=%b v=%b wr=%0d want 0/1/3", obs_stall, bus.exValid, bus.exWrReg);
      end
   endtask

   task automatic test_imm_branch();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, 32'h3022FFFF, 1'b0, 1'b0);
      n_cmp++;
      if (bus.exImm !== 32'h0000FFFF || bus.exAluCode !== A_AND) begin
         n_bad++; $display("FAIL andi_imm: got imm=%h alu=%0d want 0000ffff/2", bus.exImm, bus.exAluCode);
      end
      tick(1'b1, 32'h2022FFFF, 1'b0, 1'b0);
      n_cmp++;
      if (bus.exImm !== 32'hFFFFFFFF || bus.exRegWrite !== 1'b1 || bus.exWrReg !== 5'd2) begin
         n_bad++; $display("FAIL addi_imm: got imm=%h rw=%b wr=%0d want ffffffff/1/2", bus.exImm, bus.exRegWrite, bus.exWrReg);
      end
      tick(1'b1, 32'h14220003, 1'b0, 1'b0);
      n_cmp++;
      if (bus.exBranch !== 1'b1 || bus.exBranchNe !== 1'b1 || bus.exAluCode !== A_SUB || bus.exRegWrite !== 1'b0) begin
         n_bad++; $display("FAIL bne_ctrl: got br=%b bne=%b alu=%0d rw=%b want 1/1/1/0",
                           bus.exBranch, bus.exBranchNe, bus.exAluCode, bus.exRegWrite);
      end
   endtask

   task automatic test_illegal();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, 32'hFC000000, 1'b0, 1'b0);
      n_cmp++;
      if (bus.exIllegal !== 1'b1 || bus.exRegWrite !== 1'b0 || bus.exMemWrite !== 1'b0 || bus.exAluCode !== A_ADD) begin
         n_bad++; $display("FAIL illegal_op: got ill=%b rw=%b mw=%b alu=%0d want 1/0/0/0",
                           bus.exIllegal, bus.exRegWrite, bus.exMemWrite, bus.exAluCode);
      end
      tick(1'b1, 32'h0044183F, 1'b0, 1'b0);
      n_cmp++;
      if (bus.exIllegal !== 1'b1 || bus.exRegWrite !== 1'b0 || bus.exMemWrite !== 1'b0) begin
         n_bad++; $display("FAIL illegal_funct: got ill=%b rw=%b mw=%b want 1/0/0",
                           bus.exIllegal, bus.exRegWrite, bus.exMemWrite);
      end
   endtask

   task automatic test_flush_hazard();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, I_LW2, 1'b0, 1'b0);
      tick(1'b1, I_ADD3, 1'b1, 1'b0);
      n_cmp++;
      if (obs_stall !== 1'b0 || bus.exValid !== 1'b0 || bus.stallCount !== 16'd0) begin
         n_bad++; $display("FAIL flush_wins: got stall=%b v=%b sc=%0d want 0/0/0", obs_stall, bus.exValid, bus.stallCount);
      end
   endtask

   task automatic test_reset_mid_stall();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, I_LW2, 1'b0, 1'b0);
      tick(1'b1, I_ADD3, 1'b0, 1'b1);
      n_cmp++;
      if (bus.exValid !== 1'b0 || bus.stallCount !== 16'd0) begin
         n_bad++; $display("FAIL rst_mid_stall_ex: got v=%b sc=%0d want 0/0", bus.exValid, bus.stallCount);
      end
      tick(1'b1, I_ADD3, 1'b0, 1'b0);
      n_cmp++;
      if (obs_stall !== 1'b0 || bus.exValid !== 1'b1) begin
         n_bad++; $display("FAIL rst_mid_stall_next: got stall=%b v=%b want 0/1", obs_stall, bus.exValid);
      end
   endtask

   task automatic test_back_to_back();
      int stalls;
      stalls = 0;
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      tick(1'b1, I_LW2, 1'b0, 1'b0);  stalls += int'(obs_stall);
      tick(1'b1, I_LW3, 1'b0, 1'b0);  stalls += int'(obs_stall);
      tick(1'b1, I_LW3, 1'b0, 1'b0);  stalls += int'(obs_stall);
      tick(1'b1, I_ADD4, 1'b0, 1'b0); stalls += int'(obs_stall);
      tick(1'b1, I_ADD4, 1'b0, 1'b0); stalls += int'(obs_stall);
      n_cmp++;
      if (stalls != 2 || bus.stallCount !== 16'd2 || bus.decodeCount !== 16'd3 || bus.exWrReg !== 5'd4) begin
         n_bad++; $display("FAIL back_to_back: got stalls=%0d sc=%0d dc=%0d wr=%0d want 2/2/3/4",
                           stalls, bus.stallCount, bus.decodeCount, bus.exWrReg);
      end
   endtask

   task automatic test_random();
      logic [31:0] w;
      logic        v, f;
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      w = rand_insn(); v = 1'b1;
      for (int i = 0; i < 400; i++) begin
         f = ($urandom_range(0, 9) == 0);
         tick(v, w, f, 1'b0);
         n_cmp++;
         if (obs_stall !== exp_stall) begin
            n_bad++; $display("FAIL rand_stall[%0d]: got %b want %b insn=%h", i, obs_stall, exp_stall, w);
         end
         n_cmp++;
         if (dut_ex() !== m_ex) begin
            n_bad++; $display("FAIL rand_bundle[%0d]: got %h want %h", i, dut_ex(), m_ex);
         end
         n_cmp++;
         if (bus.decodeCount !== 16'(m_dec) || bus.stallCount !== 16'(m_stall)) begin
            n_bad++; $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d",
                              i, bus.decodeCount, bus.stallCount, m_dec, m_stall);
         end
         if (!exp_stall) begin
            w = rand_insn();
            v = ($urandom_range(0, 7) != 0);
         end
      end
   endtask

   task automatic test_saturation();
      tick(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, I_LW2, 1'b0, 1'b0);
         tick(1'b1, I_ADD3, 1'b0, 1'b0);
         tick(1'b1, I_ADD3, 1'b0, 1'b0);
         if (i == 13) begin
            n_cmp++;
            if (bus_sat.stallCount !== 4'(sat(m_stall, 15))) begin
               n_bad++; $display("FAIL sat_below: got %0d want %0d", bus_sat.stallCount, sat(m_stall, 15));
            end
         end
      end
      n_cmp++;
      if (bus_sat.stallCount !== 4'hF || m_stall != 20) begin
         n_bad++; $display("FAIL sat_stall: got %0d want 15 (model %0d)", bus_sat.stallCount, m_stall);
      end
      n_cmp++;
      if (bus_sat.decodeCount !== 4'(sat(m_dec, 15)) || bus.decodeCount !== 16'(m_dec)) begin
         n_bad++; $display("FAIL sat_decode: got %0d/%0d want %0d/%0d",
                           bus_sat.decodeCount, bus.decodeCount, sat(m_dec, 15), m_dec);
      end
      n_cmp++;
      if (bus.stallCount !== 16'd20) begin
         n_bad++; $display("FAIL wide_stall_count: got %0d want 20", bus.stallCount);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.inValid = 1'b0;     bus.insn = 32'h0;     bus.flush = 1'b0;
      bus_nh.inValid = 1'b0;  bus_nh.insn = 32'h0;  bus_nh.flush = 1'b0;
      bus_sat.inValid = 1'b0; bus_sat.insn = 32'h0; bus_sat.flush = 1'b0;
      m_ex = '0; m_dec = 0; m_stall = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_lw();
      test_load_use();
      test_zero_reg();
      test_imm_branch();
      test_illegal();
      test_flush_hazard();
      test_reset_mid_stall();
      test_back_to_back();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined instruction-decode stage for the MIPS pipeline processor. It decodes the IF/ID instruction over an extended opcode set with defined defaults for every control signal. It detects load-use hazards against the instruction it last issued and stalls fetch for one cycle. It registers the full control/operand bundle into the ID/EX boundary and supports flush on taken branch/jump, plus saturating decode and stall counters.

## Interface
- `DATA_WIDTH`, 32: immediate extension width.
- `REG_NUM_WIDTH`, 5: register index width.
- `COUNT_WIDTH`, 16: width of the performance counters.
- `HAZARD_EN`, 1: 1 enables load-use detection; 0 forces `stall`=0.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `inValid`  in  1  IF/ID register holds a real instruction.
- `insn`  in  32  instruction word (`InsnPath`).
- `flush`  in  1  squash the instruction currently in ID.
- `stall`  out  1  combinational; IF and IF/ID must hold this cycle.
- `exValid`  out  1  ID/EX holds a real instruction.
- `exOp`  out  6  opcode.
- `exRs`, `exRt`, `exRd`  out  REG_NUM_WIDTH each  register fields.
- `exWrReg`  out  REG_NUM_WIDTH  destination: `rd` if regDst, else `rt`.
- `exShamt`  out  5  shift amount.
- `exImm`  out  DATA_WIDTH  immediate: zero-extended for ANDI/ORI, sign-extended otherwise.
- `exJumpTarget`  out  26  J target field.
- `exAluCode`  out  ALUCodePath  ALU operation (`ALU_CODE_*`).
- `exAluSrc`, `exMemToReg`, `exRegWrite`, `exMemRead`, `exMemWrite`, `exBranch`, `exBranchNe`, `exJump`, `exIllegal`  out  1 each  control.
- `decodeCount`  out  COUNT_WIDTH  count of instructions issued with valid=1.
- `stallCount`  out  COUNT_WIDTH  count of stall cycles.

## Operation
- Field extraction uses `OP_POS`/`RS_POS`/`RT_POS`/`RD_POS`/`SHAMT_POS`/`FUNCT_POS` from Types.v.
- Opcodes and controls (regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, branchNe, jump):
  - R 0x00: 1,0,0,1,0,0,0,0,0.
  - LW 0x23: 0,1,1,1,1,0,0,0,0.
  - SW 0x2B: 0,1,0,0,0,1,0,0,0.
  - BEQ 0x04: all 0 except branch=1.
  - BNE 0x05: all 0 except branch=1 and branchNe=1.
  - ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D: aluSrc=1, regWrite=1, rest 0.
  - J 0x02: all 0 except jump=1.
- ALU code:
  - LW/SW/ADDI: ADD. BEQ/BNE: SUB. ANDI: AND. ORI: OR. SLTI: SLT.
  - R-type by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - J: ADD (don't-care).
- Unknown opcode, or R-type with unknown funct: every write/mem/branch/jump control is 0, aluCode=ADD, `exIllegal`=1. No signal is ever left unassigned.
- Source use for hazard checks: rs is a source for all ops except J. rt is a source for R-type, BEQ, BNE and SW.
- Load-use hazard: `exValid`&`exMemRead`&(`exWrReg`≠0)&(`exWrReg` matches a used source of `insn`)&`inValid`&`HAZARD_EN`.
- Next-state priority for the ID/EX register:
  - `rst`: all ex* outputs and counters to 0.
  - `flush`: load a bubble (all ex* outputs 0); `stall`=0.
  - hazard: load a bubble; `stall`=1.
  - otherwise: load the decoded `insn` with `exValid`=`inValid`. When `inValid`=0, all control bits are 0.
- Counters:
  - `decodeCount` increments when the loaded `exValid`=1.
  - `stallCount` increments when `stall`=1.
  - Both saturate at all-ones.

## Timing
- Decode latency is 1 cycle: `insn` sampled at edge N appears on ex* after edge N.
- `stall` is same-cycle combinational from `insn`, `inValid`, `flush` and the ID/EX register. It has no dependence on ex* of the next cycle.
- A load-use stall lasts exactly 1 cycle. The inserted bubble clears the hazard, and the held instruction issues on the following edge.
- Back-to-back loads with a dependency each stall once.
- `flush` and hazard in the same cycle: flush wins, with no stall and no stallCount increment.
- `rst` asserted mid-stall: the next cycle has `stall`=0 and `exValid`=0.
- Register $0 never triggers a hazard.

## Test plan
- Reset, then `insn`=0x8C220004 (lw $2,4($1)): one cycle later `exMemRead`=1, `exWrReg`=2, `exImm`=0x00000004, `decodeCount`=1.
- lw $2 issued, then add $3,$2,$4 (0x00441820) presented: `stall`=1 for one cycle and a bubble is issued. The next cycle issues the add with `exAluCode`=ADD and `exWrReg`=3; `stallCount`=1.
- lw $0,… followed by a user of $0: no stall. With `HAZARD_EN`=0, the lw $2/add pair also does not stall.
- ANDI with imm 0xFFFF: `exImm`=0x0000FFFF. ADDI with imm 0xFFFF: `exImm`=0xFFFFFFFF. BNE: `exBranch`=`exBranchNe`=1 and aluCode=SUB.
- Opcode 0x3F, or R-type with funct 0x3F: `exIllegal`=1, `exRegWrite`=`exMemWrite`=0.
- Hazard and `flush` in the same cycle: `stall`=0 and a bubble is issued. Force `stallCount` near max and confirm it holds at all-ones.
